// File: rtl/mux4_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mux4_scan_sequencer
// Description : Upstream scan controller for a 4:1 mux. Steps the 2-bit
//               select through the enabled channels, waits a programmable
//               dwell on each, captures the mux output and presents it
//               downstream with a valid/ready handshake. Supports a single
//               pass or continuous passes until stopped.
// Ports       : clk, rst_n (sync, active low)
//               start / continuous / stop / ch_mask / dwell : scan control
//               s -> mux select, f <- mux data
//               out_data / out_ch / out_valid / out_ready   : sample stream
//               busy (scan in progress), done (one-cycle end pulse)
// Revision    : 1.0 - initial release
// ============================================================================
module mux4_scan_sequencer #(
    parameter int DATA_W  = 3,
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               continuous,
    input  logic               stop,
    input  logic [3:0]         ch_mask,
    input  logic [DWELL_W-1:0] dwell,
    output logic [1:0]         s,
    input  logic [DATA_W-1:0]  f,
    output logic [DATA_W-1:0]  out_data,
    output logic [1:0]         out_ch,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DWELL = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t               state_q,     state_d;
    logic [1:0]           s_q,         s_d;
    logic [DATA_W-1:0]    out_data_q,  out_data_d;
    logic [1:0]           out_ch_q,    out_ch_d;
    logic                 out_valid_q, out_valid_d;
    logic                 busy_q,      busy_d;
    logic                 done_q,      done_d;
    logic [DWELL_W-1:0]   cnt_q,       cnt_d;
    logic [3:0]           mask_q,      mask_d;
    logic                 cont_q,      cont_d;
    logic                 stop_seen_q, stop_seen_d;

    logic [3:0]           above_mask;
    logic                 stop_now;

    // Index of the lowest set bit; only called with a non-zero mask.
    function automatic logic [1:0] lowest_ch(input logic [3:0] m);
        if (m[0])      return 2'd0;
        else if (m[1]) return 2'd1;
        else if (m[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    // Enabled channels strictly above the current select. For s=3 the shift
    // overflows to zero, the subtraction yields all ones and the result is
    // empty, which is exactly the wrap condition.
    assign above_mask = mask_q & ~((4'b0010 << s_q) - 4'd1);

    // A stop seen at any point while holding a sample ends the scan once
    // that sample has been handed over.
    assign stop_now = stop_seen_q | stop;

    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        cnt_d       = cnt_q;
        mask_d      = mask_q;
        cont_d      = cont_q;
        stop_seen_d = stop_seen_q;

        case (state_q)
            ST_IDLE: begin
                // start takes priority over a simultaneous stop
                if (start && (ch_mask != 4'd0)) begin
                    mask_d      = ch_mask;
                    cont_d      = continuous;
                    s_d         = lowest_ch(ch_mask);
                    cnt_d       = dwell;
                    busy_d      = 1'b1;
                    stop_seen_d = 1'b0;
                    state_d     = ST_DWELL;
                end
            end

            ST_DWELL: begin
                if (stop) begin
                    // abandon the current channel without sampling
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end else begin
                    out_data_d  = f;
                    out_ch_d    = s_q;
                    out_valid_d = 1'b1;
                    state_d     = ST_HOLD;
                end
            end

            ST_HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (stop_now) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else if (above_mask != 4'd0) begin
                        s_d     = lowest_ch(above_mask);
                        cnt_d   = dwell;
                        state_d = ST_DWELL;
                    end else if (cont_q && (ch_mask != 4'd0)) begin
                        // pass complete: pick up the current mask for the next pass
                        mask_d  = ch_mask;
                        s_d     = lowest_ch(ch_mask);
                        cnt_d   = dwell;
                        state_d = ST_DWELL;
                    end else begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end
                end else begin
                    stop_seen_d = stop_now;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            s_q         <= 2'd0;
            out_data_q  <= '0;
            out_ch_q    <= 2'd0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cnt_q       <= '0;
            mask_q      <= 4'd0;
            cont_q      <= 1'b0;
            stop_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cnt_q       <= cnt_d;
            mask_q      <= mask_d;
            cont_q      <= cont_d;
            stop_seen_q <= stop_seen_d;
        end
    end

    assign s         = s_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_mux4_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux4_scan_sequencer
// Description : Self-checking bench for mux4_scan_sequencer. A static mux
//               model (inputs 1,2,3,4) feeds f; a queue of expected samples
//               is built per scenario and checked against the output stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux4_scan_sequencer;

    localparam int DATA_W  = 3;
    localparam int DWELL_W = 4;

    typedef struct packed {
        logic [1:0]        ch;
        logic [DATA_W-1:0] data;
    } samp_t;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic               continuous;
    logic               stop;
    logic [3:0]         ch_mask;
    logic [DWELL_W-1:0] dwell;
    logic [1:0]         s;
    logic [DATA_W-1:0]  f;
    logic [DATA_W-1:0]  out_data;
    logic [1:0]         out_ch;
    logic               out_valid;
    logic               out_ready;
    logic               busy;
    logic               done;

    logic [DATA_W-1:0]  mux_in [4];
    logic [3:0]         cfg_mask;
    samp_t              exp_q [$];
    samp_t              seen_q [$];

    int n_checks = 0;
    int n_pass   = 0;

    logic               hold_prev = 1'b0;
    logic [1:0]         prev_ch   = 2'd0;
    logic [DATA_W-1:0]  prev_data = '0;
    logic               prev_done = 1'b0;

    always #5 clk = ~clk;

    assign f = mux_in[s];

    mux4_scan_sequencer #(
        .DATA_W  (DATA_W),
        .DWELL_W (DWELL_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .continuous (continuous),
        .stop       (stop),
        .ch_mask    (ch_mask),
        .dwell      (dwell),
        .s          (s),
        .f          (f),
        .out_data   (out_data),
        .out_ch     (out_ch),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Model: one pass yields the enabled channels in ascending order, each
    // carrying the value present on that mux input.
    task automatic push_pass(input logic [3:0] m);
        for (int c = 0; c < 4; c++) begin
            if (m[c]) exp_q.push_back('{ch: c[1:0], data: mux_in[c]});
        end
    endtask

    function automatic samp_t seen_at(input int i);
        if (i < seen_q.size()) return seen_q[i];
        return '{ch: 2'd3, data: '1};
    endfunction

    // Stream checker, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_prev = 1'b0;
            prev_done = 1'b0;
        end else begin
            if (hold_prev) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_ch", out_ch, prev_ch);
                chk("hold_data", out_data, prev_data);
                chk("hold_s", s, prev_ch);
            end
            if (out_valid) begin
                chk("valid_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    chk("sample_ch", out_ch, exp_q[0].ch);
                    chk("sample_data", out_data, exp_q[0].data);
                end
                chk("sample_s", s, out_ch);
            end
            if (busy) chk("s_enabled", cfg_mask[s], 1);
            if (done) begin
                chk("done_busy", busy, 0);
                chk("done_valid", out_valid, 0);
                chk("done_pending", exp_q.size(), 0);
                chk("done_single", prev_done, 0);
            end
            if (out_valid && out_ready) begin
                seen_q.push_back('{ch: out_ch, data: out_data});
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            hold_prev = out_valid && !out_ready;
            prev_ch   = out_ch;
            prev_data = out_data;
            prev_done = done;
        end
    end

    // Called aligned 1 time unit after a rising edge; the next edge samples start.
    task automatic start_scan(input logic [3:0] m, input logic [DWELL_W-1:0] dw, input logic cont);
        cfg_mask   = m;
        ch_mask    = m;
        dwell      = dw;
        continuous = cont;
        start      = 1'b1;
        @(posedge clk); #1;
        start      = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        logic got;
        got = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(posedge clk); #1;
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        chk(name, got, 1);
        @(posedge clk); #1;
        chk({name, "_low"}, done, 0);
    endtask

    task automatic wait_valid(input int budget, input string name);
        logic got;
        got = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                got = 1'b1;
                break;
            end
        end
        chk(name, got, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k;
        mux_in     = '{3'd1, 3'd2, 3'd3, 3'd4};
        rst_n      = 1'b0;
        start      = 1'b0;
        continuous = 1'b0;
        stop       = 1'b0;
        ch_mask    = 4'd0;
        dwell      = '0;
        out_ready  = 1'b0;
        cfg_mask   = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_s", s, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_ch", out_ch, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // T1: all channels, no dwell, always ready, single pass
        out_ready = 1'b1;
        seen_q.delete();
        push_pass(4'b1111);
        start_scan(4'b1111, 4'd0, 1'b0);
        chk("t1_busy", busy, 1);
        wait_done(40, "t1_done");
        chk("t1_count", seen_q.size(), 4);
        chk("t1_s0", seen_at(0), {2'd0, 3'd1});
        chk("t1_s1", seen_at(1), {2'd1, 3'd2});
        chk("t1_s2", seen_at(2), {2'd2, 3'd3});
        chk("t1_s3", seen_at(3), {2'd3, 3'd4});
        chk("t1_idle_busy", busy, 0);

        // T2: sparse mask
        seen_q.delete();
        push_pass(4'b1010);
        start_scan(4'b1010, 4'd0, 1'b0);
        wait_done(40, "t2_done");
        chk("t2_count", seen_q.size(), 2);
        chk("t2_s0", seen_at(0), {2'd1, 3'd2});
        chk("t2_s1", seen_at(1), {2'd3, 3'd4});

        // T3: back-pressure on channel 0
        out_ready = 1'b0;
        seen_q.delete();
        push_pass(4'b1111);
        start_scan(4'b1111, 4'd0, 1'b0);
        wait_valid(10, "t3_valid");
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("t3_stall_valid", out_valid, 1);
            chk("t3_stall_s", s, 0);
            chk("t3_stall_data", out_data, 1);
        end
        out_ready = 1'b1;
        wait_done(40, "t3_done");
        chk("t3_count", seen_q.size(), 4);
        chk("t3_s1", seen_at(1), {2'd1, 3'd2});

        // T4: dwell of 3 cycles
        seen_q.delete();
        push_pass(4'b0011);
        start_scan(4'b0011, 4'd3, 1'b0);
        k = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                k = i;
                break;
            end
        end
        chk("t4_first_latency", k, 4);
        @(posedge clk); #1;
        chk("t4_handshake_drop", out_valid, 0);
        k = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                k = i;
                break;
            end
        end
        chk("t4_next_latency", k, 4);
        wait_done(20, "t4_done");
        chk("t4_count", seen_q.size(), 2);

        // T5: continuous, stop during dwell of channel 2 on the second pass
        seen_q.delete();
        push_pass(4'b1111);
        push_pass(4'b0011);
        start_scan(4'b1111, 4'd2, 1'b1);
        k = 0;
        for (int i = 0; i < 100; i++) begin
            if (seen_q.size() == 6) begin
                k = 1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("t5_reach", k, 1);
        chk("t5_s_at_stop", s, 2);
        chk("t5_valid_at_stop", out_valid, 0);
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        continuous = 1'b0;
        chk("t5_done", done, 1);
        chk("t5_busy", busy, 0);
        @(posedge clk); #1;
        chk("t5_done_low", done, 0);
        chk("t5_count", seen_q.size(), 6);
        chk("t5_s3", seen_at(3), {2'd3, 3'd4});
        chk("t5_s4", seen_at(4), {2'd0, 3'd1});
        chk("t5_s5", seen_at(5), {2'd1, 3'd2});

        // T7: single channel, continuous: one sample from ch2 per pass
        seen_q.delete();
        push_pass(4'b0100);
        push_pass(4'b0100);
        push_pass(4'b0100);
        start_scan(4'b0100, 4'd0, 1'b1);
        k = 0;
        for (int i = 0; i < 60; i++) begin
            if (seen_q.size() == 3) begin
                k = 1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("t7_reach", k, 1);
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        continuous = 1'b0;
        chk("t7_done", done, 1);
        @(posedge clk); #1;
        chk("t7_count", seen_q.size(), 3);
        chk("t7_s2", seen_at(2), {2'd2, 3'd3});

        // T6: reset while holding a sample, then start with an empty mask
        out_ready = 1'b0;
        seen_q.delete();
        push_pass(4'b1111);
        start_scan(4'b1110, 4'd0, 1'b0);
        exp_q.delete();
        push_pass(4'b1110);
        wait_valid(10, "t6_valid");
        chk("t6_pre_ch", out_ch, 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        exp_q.delete();
        chk("t6_s", s, 0);
        chk("t6_out_data", out_data, 0);
        chk("t6_out_ch", out_ch, 0);
        chk("t6_out_valid", out_valid, 0);
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        start_scan(4'b0000, 4'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("t6_empty_busy", busy, 0);
            chk("t6_empty_valid", out_valid, 0);
            @(posedge clk); #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
